// File: rtl/gpio_pkg.sv
// Shared types and the seven-segment decode for the GPIO CSR port.
// The segment patterns are active-low, with bit 6 = g and bit 0 = a.
package gpio_pkg;

  typedef enum logic {
    S_STABLE = 1'b0,
    S_COUNT  = 1'b1
  } deb_state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_DIGITS = 8;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/gpio_csr_port_if.sv
// CSR-side signal bundle for the GPIO port.
// The master side is the pipeline and board; the slave side is gpio_csr_port.
interface gpio_csr_port_if #(
  parameter int NUM_SW = 18
);
  logic              gpio_we;
  logic              stall_EX;
  logic [31:0]       gpio_wdata;
  logic [NUM_SW-1:0] sw_raw;
  logic [31:0]       sw_rdata;
  logic              sw_changed;
  logic [31:0]       hex_value;
  logic [55:0]       hex_seg;

  modport master (
    output gpio_we, stall_EX, gpio_wdata, sw_raw,
    input  sw_rdata, sw_changed, hex_value, hex_seg
  );

  modport slave (
    input  gpio_we, stall_EX, gpio_wdata, sw_raw,
    output sw_rdata, sw_changed, hex_value, hex_seg
  );
endinterface

// File: rtl/gpio_csr_port_sw_debounce.sv
// Switch synchroniser and debouncer.
// A new switch value is accepted only after it holds for DEBOUNCE_CYCLES cycles.
module sw_debounce
  import gpio_pkg::*;
#(
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [31:0]       sw_rdata,
  output logic              sw_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync1_reg;
  logic [NUM_SW-1:0] sync2_reg;

  deb_state_t        state_reg,  state_next;
  logic [NUM_SW-1:0] cand_reg,   cand_next;
  logic [CNT_W-1:0]  cnt_reg,    cnt_next;
  logic [31:0]       rdata_reg,  rdata_next;
  logic              changed_reg, changed_next;

  logic [NUM_SW-1:0] sw_sync;
  logic [NUM_SW-1:0] stable;

  assign sw_sync = sync2_reg;
  assign stable  = rdata_reg[NUM_SW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      state_reg   <= S_STABLE;
      cand_reg    <= '0;
      cnt_reg     <= '0;
      rdata_reg   <= '0;
      changed_reg <= 1'b0;
    end else begin
      sync1_reg   <= sw_raw;
      sync2_reg   <= sync1_reg;
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      cnt_reg     <= cnt_next;
      rdata_reg   <= rdata_next;
      changed_reg <= changed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    rdata_next   = rdata_reg;
    changed_next = 1'b0;

    case (state_reg)
      S_STABLE: begin
        cnt_next = '0;
        if (sw_sync != stable) begin
          state_next = S_COUNT;
          cand_next  = sw_sync;
        end
      end
      S_COUNT: begin
        if (sw_sync != cand_reg) begin
          // A bounce back to the accepted value abandons the candidate entirely.
          cnt_next = '0;
          if (sw_sync == stable) begin
            state_next = S_STABLE;
          end else begin
            cand_next = sw_sync;
          end
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next               = '0;
          rdata_next[NUM_SW-1:0]   = cand_reg;
          changed_next             = 1'b1;
          state_next               = S_STABLE;
          cnt_next                 = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign sw_rdata   = rdata_reg;
  assign sw_changed = changed_reg;

endmodule

// File: rtl/gpio_csr_port.sv
// GPIO responder on the CSR path: HEX display register (0xF02) and
// debounced switch read value (0xF00).
module gpio_csr_port
  import gpio_pkg::*;
#(
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  gpio_csr_port_if.slave  bus
);

  logic [31:0] hex_value_reg;
  logic [55:0] hex_seg_reg;
  logic [55:0] hex_seg_next;
  logic        hex_wr;

  // stall_EX is tested first so an unknown gpio_we during a stall cannot leak in.
  assign hex_wr = (bus.stall_EX == 1'b0) && (bus.gpio_we == 1'b1);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign hex_seg_next[7*gi +: 7] = hex_to_seg(bus.gpio_wdata[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_value_reg <= '0;
      hex_seg_reg   <= {NUM_DIGITS{SEG_BLANK}};
    end else if (hex_wr) begin
      hex_value_reg <= bus.gpio_wdata;
      hex_seg_reg   <= hex_seg_next;
    end
  end

  assign bus.hex_value = hex_value_reg;
  assign bus.hex_seg   = hex_seg_reg;

  sw_debounce #(
    .NUM_SW          (NUM_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_debounce (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (bus.sw_raw),
    .sw_rdata   (bus.sw_rdata),
    .sw_changed (bus.sw_changed)
  );

endmodule

// File: tb/tb_gpio_csr_port.sv
// Self-checking bench for gpio_csr_port with a short debounce window.
module tb_gpio_csr_port;

  localparam int NUM_SW = 18;
  localparam int DEB    = 4;
  localparam int SW_LAT = 2 + DEB + 1;

  typedef struct {
    logic [31:0] value;
    int          latency;
  } sw_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_csr_port_if #(.NUM_SW(NUM_SW)) bus_if ();

  gpio_csr_port #(
    .NUM_SW          (NUM_SW),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [31:0] hex_q[$];
  sw_exp_t     sw_q[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [55:0] exp_seg(input logic [31:0] v);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = seg_tab[v[4*i +: 4]];
    return r;
  endfunction

  // Watches for sw_changed pulses; reports first-pulse latency (-1 if none).
  task automatic watch_sw(input int max_cyc, output int lat, output int pulses);
    int start;
    start  = cyc;
    lat    = -1;
    pulses = 0;
    repeat (max_cyc) begin
      @(posedge clk); #1;
      if (bus_if.sw_changed === 1'b1) begin
        pulses++;
        if (lat < 0) lat = cyc - start;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b1;
    bus_if.gpio_we = 1'b0; bus_if.stall_EX = 1'b0;
    bus_if.gpio_wdata = '0; bus_if.sw_raw = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus_if.hex_seg !== {56{1'b1}}) begin errors++; $display("FAIL reset_hex_seg got %h want %h", bus_if.hex_seg, {56{1'b1}}); end
    checks++; if (bus_if.hex_value !== 32'h0) begin errors++; $display("FAIL reset_hex_value got %h want 0", bus_if.hex_value); end
    checks++; if (bus_if.sw_rdata !== 32'h0 || bus_if.sw_changed !== 1'b0) begin errors++; $display("FAIL reset_sw got %h/%b want 0/0", bus_if.sw_rdata, bus_if.sw_changed); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    bus_if.gpio_we = 1'b1; bus_if.gpio_wdata = 32'hDEADBEEF; hex_q.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    bus_if.gpio_we = 1'b0;
    e = hex_q.pop_front();
    checks++; if (bus_if.hex_value !== e) begin errors++; $display("FAIL pre_reset_write got %h want %h", bus_if.hex_value, e); end
    // Mid-cycle reset must take effect without a clock edge.
    @(negedge clk); #2 rst = 1'b1; #1;
    checks++; if (bus_if.hex_value !== 32'h0 || bus_if.hex_seg !== {56{1'b1}} || bus_if.sw_rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset got hv=%h seg=%h sw=%h want 0/all-ones/0", bus_if.hex_value, bus_if.hex_seg, bus_if.sw_rdata);
    end
    $display("test_reset: async reset cleared outputs at t=%0t", $time);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_write();
    logic [31:0] e;
    logic [31:0] vals [3];
    vals = '{32'h0123ABCD, 32'h89ABCDEF, 32'h00000000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.gpio_we = 1'b1; bus_if.stall_EX = 1'b0; bus_if.gpio_wdata = vals[i];
      hex_q.push_back(vals[i]);
      @(posedge clk); #1;
      e = hex_q.pop_front();
      checks++; if (bus_if.hex_value !== e) begin errors++; $display("FAIL write_value[%0d] got %h want %h", i, bus_if.hex_value, e); end
      checks++; if (bus_if.hex_seg !== exp_seg(e)) begin errors++; $display("FAIL write_seg[%0d] got %h want %h", i, bus_if.hex_seg, exp_seg(e)); end
      if (i == 0) begin
        checks++; if (bus_if.hex_seg[6:0] !== 7'h21 || bus_if.hex_seg[55:49] !== 7'h40) begin
          errors++; $display("FAIL digit0_digit7 got %h/%h want 21/40", bus_if.hex_seg[6:0], bus_if.hex_seg[55:49]);
        end
        bus_if.gpio_we = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (bus_if.hex_value !== e) begin errors++; $display("FAIL write_hold got %h want %h", bus_if.hex_value, e); end
      end
      $display("test_write: wrote %h, hex_seg=%h", vals[i], bus_if.hex_seg);
    end
    bus_if.gpio_we = 1'b0;
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus_if.gpio_we = 1'b1; bus_if.stall_EX = 1'b1; bus_if.gpio_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    checks++; if (bus_if.hex_value !== 32'h0) begin errors++; $display("FAIL stall_write got %h want 0", bus_if.hex_value); end
    @(negedge clk) bus_if.gpio_we = 1'bx;
    @(posedge clk); #1;
    checks++; if (bus_if.hex_value !== 32'h0 || bus_if.hex_seg !== exp_seg(32'h0)) begin
      errors++; $display("FAIL stall_we_x got hv=%h seg=%h want 0/%h", bus_if.hex_value, bus_if.hex_seg, exp_seg(32'h0));
    end
    $display("test_stall: hex_value=%h after stalled writes", bus_if.hex_value);
    @(negedge clk);
    bus_if.gpio_we = 1'b0; bus_if.stall_EX = 1'b0;
  endtask

  task automatic test_switch();
    sw_exp_t e;
    int lat, pulses;
    @(negedge clk);
    bus_if.sw_raw = 18'h00005;
    sw_q.push_back('{32'h5, SW_LAT});
    watch_sw(12, lat, pulses);
    e = sw_q.pop_front();
    checks++; if (lat != e.latency) begin errors++; $display("FAIL sw_latency got %0d want %0d", lat, e.latency); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL sw_pulse_count got %0d want 1", pulses); end
    checks++; if (bus_if.sw_rdata !== e.value) begin errors++; $display("FAIL sw_value got %h want %h", bus_if.sw_rdata, e.value); end
    checks++; if (bus_if.sw_rdata[31:18] !== 14'h0) begin errors++; $display("FAIL sw_upper got %h want 0", bus_if.sw_rdata[31:18]); end
    $display("test_switch: sw_rdata=%h latency=%0d pulses=%0d", bus_if.sw_rdata, lat, pulses);
  endtask

  task automatic test_glitch();
    sw_exp_t e;
    int lat, pulses, gl_pulses, bad;
    logic [NUM_SW-1:0] pat [4];
    pat = '{18'h1, 18'h0, 18'h1, 18'h0};
    @(negedge clk) begin bus_if.sw_raw = '0; rst = 1'b1; end
    @(negedge clk) rst = 1'b0;
    gl_pulses = 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) bus_if.sw_raw = pat[i];
      repeat (2) begin
        @(posedge clk); #1;
        if (bus_if.sw_changed === 1'b1) gl_pulses++;
        if (bus_if.sw_rdata !== 32'h0) bad++;
      end
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_if.sw_changed === 1'b1) gl_pulses++;
      if (bus_if.sw_rdata !== 32'h0) bad++;
    end
    checks++; if (gl_pulses != 0 || bad != 0) begin errors++; $display("FAIL glitch_reject got pulses=%0d nonzero=%0d want 0/0", gl_pulses, bad); end
    @(negedge clk) bus_if.sw_raw = 18'h1;
    sw_q.push_back('{32'h1, SW_LAT});
    watch_sw(12, lat, pulses);
    e = sw_q.pop_front();
    checks++; if (lat != e.latency || pulses != 1 || bus_if.sw_rdata !== e.value) begin
      errors++; $display("FAIL glitch_settle got lat=%0d pulses=%0d sw=%h want %0d/1/%h", lat, pulses, bus_if.sw_rdata, e.latency, e.value);
    end
    $display("test_glitch: glitches rejected, settled sw_rdata=%h", bus_if.sw_rdata);
  endtask

  task automatic test_back_to_back();
    sw_exp_t     se;
    logic [31:0] he;
    int start, lat, pulses;
    @(negedge clk) bus_if.sw_raw = 18'h3;
    sw_q.push_back('{32'h3, SW_LAT});
    start = cyc;
    repeat (SW_LAT - 1) @(posedge clk);
    @(negedge clk);
    bus_if.gpio_we = 1'b1; bus_if.gpio_wdata = 32'hCAFEF00D;
    hex_q.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    bus_if.gpio_we = 1'b0;
    se = sw_q.pop_front();
    he = hex_q.pop_front();
    checks++; if (cyc - start != se.latency || bus_if.sw_rdata !== se.value || bus_if.sw_changed !== 1'b1) begin
      errors++; $display("FAIL simul_sw got cyc=%0d sw=%h chg=%b want %0d/%h/1", cyc - start, bus_if.sw_rdata, bus_if.sw_changed, se.latency, se.value);
    end
    checks++; if (bus_if.hex_value !== he || bus_if.hex_seg !== exp_seg(he)) begin
      errors++; $display("FAIL simul_hex got %h want %h", bus_if.hex_value, he);
    end
    $display("test_back_to_back: same-edge hex=%h sw=%h", bus_if.hex_value, bus_if.sw_rdata);

    // Reset while a new candidate is being counted.
    @(negedge clk) bus_if.sw_raw = 18'h2;
    repeat (4) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1; #1;
    checks++; if (bus_if.sw_rdata !== 32'h0 || bus_if.sw_changed !== 1'b0 || bus_if.hex_value !== 32'h0) begin
      errors++; $display("FAIL reset_mid_count got sw=%h chg=%b hv=%h want 0/0/0", bus_if.sw_rdata, bus_if.sw_changed, bus_if.hex_value);
    end
    @(negedge clk) rst = 1'b0;
    sw_q.push_back('{32'h2, SW_LAT});
    watch_sw(12, lat, pulses);
    se = sw_q.pop_front();
    checks++; if (lat != se.latency || pulses != 1 || bus_if.sw_rdata !== se.value) begin
      errors++; $display("FAIL redebounce got lat=%0d pulses=%0d sw=%h want %0d/1/%h", lat, pulses, bus_if.sw_rdata, se.latency, se.value);
    end
    $display("test_back_to_back: re-debounced after reset sw=%h latency=%0d", bus_if.sw_rdata, lat);
  endtask

  initial begin
    test_reset();
    test_write();
    test_stall();
    test_switch();
    test_glitch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gpio_csr_port.md
Name: gpio_csr_port

Overview:
- GPIO responder for the CPU's CSR I/O path.
- Captures CSR 0xF02 writes (`gpio_we` qualified by `stall_EX`) into a 32-bit HEX register and drives eight active-low seven-segment digits.
- Synchronises and debounces the board switches and presents them as the 32-bit read value for CSR 0xF00.
- Sits beside the register file and writeback mux in the EX/WB stage.

Parameters:
- NUM_SW, 18, number of switch inputs (1..32).
- DEBOUNCE_CYCLES, 500000, cycles a new switch value must hold before it is accepted (≥2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- gpio_we  in  1  HEX write request from control.
- stall_EX  in  1  EX stall. When 1, `gpio_we` is ignored, including X values.
- gpio_wdata  in  32  value to display (rs1 data).
- sw_raw  in  NUM_SW  asynchronous switch pins.
- sw_rdata  out  32  debounced switches, zero-extended; registered.
- sw_changed  out  1  one-cycle pulse when `sw_rdata` updates.
- hex_value  out  32  last written HEX value.
- hex_seg  out  56  digit i occupies [7i+6:7i], active-low gfedcba; digit 0 shows `hex_value[3:0]`.

Behaviour:
- Reset values (asynchronous, immediate):
  - `hex_value` = 0.
  - `hex_seg` = all ones (blank).
  - `sw_rdata` = 0; `sw_changed` = 0.
  - Sync flops = 0; debounce state = S_STABLE; counter = 0.
- HEX write:
  - At a rising edge with `gpio_we`==1 and `stall_EX`==0: `hex_value` <= `gpio_wdata`, and `hex_seg` <= per-nibble decode of `gpio_wdata`. Both are visible after that edge (1-cycle latency).
  - Otherwise both hold.
  - Back-to-back writes: the last one wins each cycle.
  - `hex_seg` stays blank until the first write after reset. A write of 0 shows "00000000", not blank.
- Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- Switch sync: a 2-flop synchroniser on the whole vector produces `sw_sync`.
- Debounce FSM states: S_STABLE, S_COUNT. It holds `cand` and `cnt`.
  - S_STABLE, `sw_sync` == `sw_rdata[NUM_SW-1:0]`: stay; `cnt` = 0.
  - S_STABLE, `sw_sync` differs: go to S_COUNT; `cand` <= `sw_sync`; `cnt` <= 0.
  - S_COUNT, `sw_sync` != `cand`, and `sw_sync` == stable: go to S_STABLE; `cnt` <= 0.
  - S_COUNT, `sw_sync` != `cand`, and `sw_sync` differs from stable: `cand` <= `sw_sync`; `cnt` <= 0; stay in S_COUNT.
  - S_COUNT, `sw_sync` == `cand`, `cnt` < DEBOUNCE_CYCLES-1: `cnt`++.
  - S_COUNT, `sw_sync` == `cand`, `cnt` == DEBOUNCE_CYCLES-1: `sw_rdata` <= zero-extended `cand`; `sw_changed` <= 1 for one cycle; go to S_STABLE; `cnt` <= 0.
- Latency from a clean switch change to `sw_rdata`: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- `sw_rdata[31:NUM_SW]` is always 0.
- `cnt` never wraps; it saturates only at the transition above.
- HEX writes and switch debouncing are independent; simultaneous events both take effect.
- Reset mid-count: counter and state are cleared and `sw_rdata` returns to 0. After reset, a held non-zero switch value is re-debounced from scratch.

Decomposition:
- Package `gpio_pkg`:
  - Debounce state enum (S_STABLE, S_COUNT).
  - SEG_BLANK = 7'h7F.
  - Function `hex_to_seg(logic [3:0]) -> logic [6:0]` holding the table above.
- Sub-module `sw_debounce`: parameterised by NUM_SW and DEBOUNCE_CYCLES; contains synchroniser, FSM, `sw_rdata`, `sw_changed`. Instantiated once.
- HEX register and decode live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, NUM_SW=18):
1. Assert `rst` mid-cycle → `hex_seg`=all ones, `hex_value`=0, `sw_rdata`=0 immediately, without waiting for a clock edge.
2. `gpio_we`=1, `stall_EX`=0, `gpio_wdata`=0x0123ABCD for one cycle → after the edge, `hex_value`=0x0123ABCD, digit0=0x21 (d), digit7=0x40 (0); value holds with `gpio_we`=0.
3. `gpio_we`=1, `stall_EX`=1, `gpio_wdata`=0xFFFFFFFF; then `gpio_we`=X with `stall_EX`=1 → `hex_value` unchanged, no X on outputs.
4. `sw_raw` 0→0x00005 held steady → `sw_rdata`=0x00000005 exactly 7 cycles after the change; `sw_changed` high for 1 cycle; bits 31:18 are 0.
5. `sw_raw` toggles 0x1→0x0→0x1 with 2-cycle glitches, each shorter than 4 cycles → `sw_rdata` stays 0 and `sw_changed` never pulses. When it finally holds 0x1, `sw_rdata` updates once.
6. A HEX write at the same edge a debounce completes → `hex_value` and `sw_rdata` both update on that edge. Then assert `rst` during S_COUNT → `sw_rdata`=0 and the count restarts from 0.
